counter_updown_param_1clk_async_resetn: RTL and testbench
=========================================================

# counter_updown_param_1clk_async_resetn

Parametrised up/down counter for the simple-registers counter family. It generalises the fixed-width, up-only counter to:
- configurable width and modulo;
- runtime direction;
- wrap or saturate mode;
- clock-enable prescaler;
- synchronous load;
- registered terminal-count pulse.

It is a standalone leaf block used as a benchmark and as a timebase/event counter inside larger register designs.

## Interface
- WIDTH, 12, counter width in bits (≥ 2)
- MAX_VALUE, 2**WIDTH-1, highest count value; range is 0..MAX_VALUE (1 ≤ MAX_VALUE ≤ 2**WIDTH-1)
- PRESCALE, 1, enabled cycles per count step (1..65535); 1 = step on every enabled cycle
- SATURATE, 0, 0 = wrap at limits, 1 = hold at limits

Ports:
- clk  input  1  single clock, all state on rising edge
- resetn  input  1  asynchronous, active-low reset
- en  input  1  count enable; low freezes count and prescaler
- up_down  input  1  1 = count up, 0 = count down; sampled on each step
- load  input  1  synchronous load strobe
- load_value  input  WIDTH  value to load
- count  output  WIDTH  registered counter value
- tc  output  1  registered terminal-count pulse

## Operation
- Reset (resetn low, asynchronous, any time):
  - count = 0, tc = 0, prescaler = 0.
  - Release is synchronous to clk.
  - The first possible step happens on the first rising edge with resetn high.
- Priority per rising edge: reset > load > enable.
- Load:
  - count ← min(load_value, MAX_VALUE); prescaler ← 0; tc ← 0.
  - en is ignored in that cycle.
- Prescaler:
  - Internal counter pre, width clog2(PRESCALE) (min 1 bit).
  - When en=1 and load=0:
    - if pre == PRESCALE-1, a step occurs and pre ← 0;
    - else pre ← pre+1.
  - PRESCALE=1: every enabled cycle is a step.
- Step, up (up_down=1):
  - count < MAX_VALUE: count+1.
  - count == MAX_VALUE: limit event. Wrap mode → 0; saturate mode → holds MAX_VALUE.
- Step, down (up_down=0):
  - count > 0: count-1.
  - count == 0: limit event. Wrap mode → MAX_VALUE; saturate mode → holds 0.
- tc:
  - Set to 1 on the edge where a limit event is processed; 0 on every other edge.
  - In saturate mode it pulses once per blocked step attempt at the limit. With PRESCALE=1 and en held, it stays high continuously.
- Direction change is allowed on any cycle and takes effect on the next step. It does not clear pre.
- Arithmetic: unsigned, WIDTH bits, no intermediate overflow. With MAX_VALUE < 2**WIDTH-1, values above MAX_VALUE are unreachable except via clamped load.

## Timing
- Latency: en/load/up_down are sampled at edge N; count and tc change after edge N. No combinational input-to-output paths.
- count and tc are direct flop outputs.
- tc high coincides with the first cycle count shows the post-limit value (0 or MAX_VALUE after a wrap; the held value when saturated).
- With PRESCALE=P and en held high from reset release, the first step lands on the P-th rising edge.
- Simultaneous load and en:
  - load wins;
  - the prescaler restarts, so the next step needs P further enabled cycles.
- en low mid-prescale: pre holds its value and resumes where it stopped.
- Reset asserted mid-count: outputs go to 0 immediately, without waiting for a clock edge.

## Test plan
Unless stated otherwise, WIDTH=4, MAX_VALUE=9, PRESCALE=1, SATURATE=0.

- **Reset:** apply resetn=0 between clock edges with count=5 → count=0 and tc=0 before the next edge. Release with en=1, up_down=1 → count goes 1, 2, 3 on successive edges.
- **Up wrap:** en=1, up_down=1 from 0 → count 1..9, then 0. tc=1 only in the cycle count=0, and again 10 cycles later.
- **Down wrap:** en=1, up_down=0 from 2 → count 1, 0, 9 with tc=1 when count=9, then 8.
- **Saturate (SATURATE=1):**
  - up from 8 → 9, then 9, 9 with tc=1 on each held cycle;
  - switch up_down=0 → 8, with tc=0.
- **Prescale (PRESCALE=3):**
  - en=1 → count increments every 3rd edge: 0,0,1,1,1,2.
  - Drop en for 2 cycles mid-prescale → step is delayed by exactly 2 cycles.
- **Load:**
  - load=1, load_value=6 with en=1 → count=6, tc=0, and the next step comes after a full prescale period.
  - load_value=15 → count=9 (clamped).

Source files
------------

// File: rtl/counter_updown_param_1clk_async_resetn.sv
// ============================================================================
// counter_updown_param_1clk_async_resetn : up/down counter, wrap/saturate,
// prescaled enable, synchronous clamped load, registered terminal-count pulse
// Revision: 1.0
// ============================================================================
`default_nettype none

module counter_updown_param_1clk_async_resetn #(
  parameter int WIDTH     = 12,
  parameter int MAX_VALUE = 2**WIDTH - 1,
  parameter int PRESCALE  = 1,
  parameter int SATURATE  = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam bit               SAT      = (SATURATE != 0);

  logic [PRE_W-1:0] pre;
  logic [PRE_W-1:0] pre_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic [WIDTH-1:0] load_clamped;
  logic             step;

  assign load_clamped = (load_value > MAX_V) ? MAX_V : load_value;
  assign step         = en && !load && (pre == PRE_LAST);

  always_comb begin
    count_nxt = count;
    tc_nxt    = 1'b0;
    pre_nxt   = pre;
    if (load) begin
      count_nxt = load_clamped;
      pre_nxt   = '0;
    end else if (en) begin
      pre_nxt = step ? '0 : pre + PRE_W'(1);
    end

    // A limit event produces tc whether the count wraps or is held.
    if (step) begin
      if (up_down) begin
        if (count >= MAX_V) begin
          tc_nxt    = 1'b1;
          count_nxt = SAT ? MAX_V : '0;
        end else begin
          count_nxt = count + ONE;
        end
      end else begin
        if (count == '0) begin
          tc_nxt    = 1'b1;
          count_nxt = SAT ? '0 : MAX_V;
        end else begin
          count_nxt = count - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
      tc    <= 1'b0;
      pre   <= '0;
    end else begin
      count <= count_nxt;
      tc    <= tc_nxt;
      pre   <= pre_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_counter_updown_param_1clk_async_resetn.sv
// Directed bench: wrap/P=1 instance is table-driven; saturate and prescale
// instances are checked with hand-written sequences.
`default_nettype none

module tb_counter_updown_param_1clk_async_resetn;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       en = 1'b0;
  logic       up_down = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_value = 4'd0;
  logic [3:0] count_a, count_s, count_p;
  logic       tc_a, tc_s, tc_p;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic       en;
    logic       up_down;
    logic       load;
    logic [3:0] load_value;
    int         exp_count;
    int         exp_tc;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  counter_updown_param_1clk_async_resetn #(
    .WIDTH(4), .MAX_VALUE(9), .PRESCALE(1), .SATURATE(0)
  ) dut_a (
    .clk(clk), .resetn(resetn), .en(en), .up_down(up_down), .load(load),
    .load_value(load_value), .count(count_a), .tc(tc_a)
  );

  counter_updown_param_1clk_async_resetn #(
    .WIDTH(4), .MAX_VALUE(9), .PRESCALE(1), .SATURATE(1)
  ) dut_s (
    .clk(clk), .resetn(resetn), .en(en), .up_down(up_down), .load(load),
    .load_value(load_value), .count(count_s), .tc(tc_s)
  );

  counter_updown_param_1clk_async_resetn #(
    .WIDTH(4), .MAX_VALUE(9), .PRESCALE(3), .SATURATE(0)
  ) dut_p (
    .clk(clk), .resetn(resetn), .en(en), .up_down(up_down), .load(load),
    .load_value(load_value), .count(count_p), .tc(tc_p)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic e, input logic ud, input logic ld,
                         input logic [3:0] lv, input int ec, input int et);
    vec_t v;
    v.en = e; v.up_down = ud; v.load = ld; v.load_value = lv;
    v.exp_count = ec; v.exp_tc = et;
    vecs.push_back(v);
  endtask

  // Advance one rising edge and land 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic ud, input logic ld, input logic [3:0] lv);
    en = e; up_down = ud; load = ld; load_value = lv;
  endtask

  task automatic chk_p(input string name, input int ec, input int et);
    tick();
    chk({name, " count"}, int'(count_p), ec);
    chk({name, " tc"}, int'(tc_p), et);
  endtask

  task automatic chk_s(input string name, input int ec, input int et);
    tick();
    chk({name, " count"}, int'(count_s), ec);
    chk({name, " tc"}, int'(tc_s), et);
  endtask

  initial begin
    // Table for the wrap / PRESCALE=1 instance, starting from count 0.
    for (int i = 1; i <= 9; i++) add_vec(1, 1, 0, 4'd0, i, 0);
    add_vec(1, 1, 0, 4'd0,  0, 1);
    add_vec(1, 1, 0, 4'd0,  1, 0);
    add_vec(0, 1, 0, 4'd0,  1, 0);
    add_vec(1, 0, 1, 4'd2,  2, 0);
    add_vec(1, 0, 0, 4'd0,  1, 0);
    add_vec(1, 0, 0, 4'd0,  0, 0);
    add_vec(1, 0, 0, 4'd0,  9, 1);
    add_vec(1, 0, 0, 4'd0,  8, 0);
    add_vec(1, 1, 1, 4'd15, 9, 0);
    add_vec(0, 1, 0, 4'd0,  9, 0);
    add_vec(1, 1, 0, 4'd0,  0, 1);
    add_vec(1, 1, 1, 4'd6,  6, 0);
    add_vec(1, 1, 0, 4'd0,  7, 0);
    add_vec(0, 0, 1, 4'd9,  9, 0);
    add_vec(1, 1, 0, 4'd0,  0, 1);

    #1;
    chk("reset count_a", int'(count_a), 0);
    chk("reset tc_a", int'(tc_a), 0);
    chk("reset count_s", int'(count_s), 0);
    chk("reset count_p", int'(count_p), 0);
    tick();
    tick();
    resetn = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].up_down, vecs[i].load, vecs[i].load_value);
      tick();
      chk($sformatf("vec%0d count", i), int'(count_a), vecs[i].exp_count);
      chk($sformatf("vec%0d tc", i), int'(tc_a), vecs[i].exp_tc);
    end

    // Second wrap: tc returns exactly 10 steps after the previous one.
    drive(1, 1, 0, 4'd0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("rewrap%0d count", i), int'(count_a), i % 10);
      chk($sformatf("rewrap%0d tc", i), int'(tc_a), (i == 10) ? 1 : 0);
    end

    // Asynchronous reset while tc is high, between edges.
    #2 resetn = 1'b0;
    #1;
    chk("async rst tc", int'(tc_a), 0);
    chk("async rst count", int'(count_a), 0);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 1; i <= 5; i++) tick();
    chk("pre-reset count", int'(count_a), 5);
    #2 resetn = 1'b0;
    #1;
    chk("async rst from 5", int'(count_a), 0);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("release step%0d", i), int'(count_a), i);
    end

    // Saturate instance.
    drive(0, 1, 1, 4'd8);
    chk_s("sat load8", 8, 0);
    drive(1, 1, 0, 4'd0);
    chk_s("sat up9", 9, 0);
    chk_s("sat hold1", 9, 1);
    chk_s("sat hold2", 9, 1);
    up_down = 1'b0;
    chk_s("sat down8", 8, 0);
    drive(0, 0, 1, 4'd1);
    chk_s("sat load1", 1, 0);
    drive(1, 0, 0, 4'd0);
    chk_s("sat down0", 0, 0);
    chk_s("sat hold0", 0, 1);

    // Prescale=3 instance from a fresh reset release.
    drive(0, 0, 0, 4'd0);
    resetn = 1'b0;
    tick();
    tick();
    drive(1, 1, 0, 4'd0);
    resetn = 1'b1;
    chk_p("pre e1", 0, 0);
    chk_p("pre e2", 0, 0);
    chk_p("pre e3", 1, 0);
    chk_p("pre e4", 1, 0);
    chk_p("pre e5", 1, 0);
    chk_p("pre e6", 2, 0);
    chk_p("pre e7", 2, 0);
    en = 1'b0;
    chk_p("pre pause1", 2, 0);
    chk_p("pre pause2", 2, 0);
    en = 1'b1;
    chk_p("pre resume1", 2, 0);
    chk_p("pre resume2", 3, 0);
    chk_p("pre mid", 3, 0);
    drive(1, 1, 1, 4'd6);
    chk_p("pre load6", 6, 0);
    drive(1, 1, 0, 4'd0);
    chk_p("pre after load1", 6, 0);
    chk_p("pre after load2", 6, 0);
    chk_p("pre after load3", 7, 0);
    drive(1, 1, 1, 4'd15);
    chk_p("pre load clamp", 9, 0);
    drive(1, 1, 0, 4'd0);
    chk_p("pre wrap1", 9, 0);
    chk_p("pre wrap2", 9, 0);
    chk_p("pre wrap3", 0, 1);
    chk_p("pre wrap4", 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
